// File: rtl/liteeth_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : liteeth_sram_pkg
// Purpose  : Shared types and default geometry for the liteeth 1RW1R SRAM
//            RW-port arbiter (state encoding, requester id, default sizes).
// Revision : 1.0 - initial release
// ============================================================================
package liteeth_sram_pkg;

    localparam int DEFAULT_BITS       = 32;
    localparam int DEFAULT_WORD_DEPTH = 384;
    localparam int DEFAULT_ADDR_WIDTH = 9;

    // ST_INIT only exists when the zero-fill engine is compiled in.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Requester index: 0 or 1.
    typedef logic req_id_t;

endpackage
`default_nettype wire

// File: rtl/liteeth_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : liteeth_rr_arb2
// Purpose  : Two-way round-robin arbiter. The grant is combinational from the
//            valid inputs and the priority pointer; the pointer flips to the
//            other requester after every grant.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            en            - arbitration enable (no grants while low)
//            valid0/valid1 - requests
//            grant0/grant1 - one-hot grant (at most one high)
//            gnt_any       - some requester granted this cycle
//            gnt_id        - index of the granted requester
// Revision : 1.0 - initial release
// ============================================================================
module liteeth_rr_arb2
    import liteeth_sram_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    en,
    input  logic    valid0,
    input  logic    valid1,
    output logic    grant0,
    output logic    grant1,
    output logic    gnt_any,
    output req_id_t gnt_id
);

    req_id_t r_prio;
    logic    w_pick1;

    // Requester 1 wins when it is alone or when both ask and it holds priority.
    assign w_pick1 = valid1 && (!valid0 || r_prio);
    assign gnt_id  = w_pick1;
    assign gnt_any = en && (valid0 || valid1);
    assign grant0  = en && valid0 && !w_pick1;
    assign grant1  = en && valid1 && w_pick1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (gnt_any) begin
            r_prio <= ~gnt_id;
        end
    end

endmodule
`default_nettype wire

// File: rtl/liteeth_sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : liteeth_sram_rw_arbiter
// Purpose  : Shares the RW port of a 1RW1R SRAM macro between two requesters
//            with round-robin arbitration, read-response routing and
//            out-of-range protection. Optional zero-fill after reset when
//            SRAM_CTRL_INIT_EN is defined.
// Ports    : clk0, rst                 - clock, sync active-high reset
//            reqN_*  (N=0,1)           - valid/ready command channel
//            rspN_*  (N=0,1)           - read response (valid, rdata, err)
//            ce_rw1, we_in_rw1, addr_rw1, wd_in_rw1, w_mask_rw1 - macro drive
//            rd_out_rw1                - macro registered read data
//            init_done                 - block accepts requests
// Macro    : SRAM_CTRL_INIT_EN - compile in the post-reset zero-fill engine
// Revision : 1.0 - initial release
// ============================================================================
module liteeth_sram_rw_arbiter
    import liteeth_sram_pkg::*;
#(
    parameter int BITS       = DEFAULT_BITS,
    parameter int WORD_DEPTH = DEFAULT_WORD_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [BITS-1:0]       req0_wdata,
    input  logic [BITS-1:0]       req0_wmask,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [BITS-1:0]       req1_wdata,
    input  logic [BITS-1:0]       req1_wmask,
    output logic                  rsp0_valid,
    output logic [BITS-1:0]       rsp0_rdata,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [BITS-1:0]       rsp1_rdata,
    output logic                  rsp1_err,
    output logic                  ce_rw1,
    output logic                  we_in_rw1,
    output logic [ADDR_WIDTH-1:0] addr_rw1,
    output logic [BITS-1:0]       wd_in_rw1,
    output logic [BITS-1:0]       w_mask_rw1,
    input  logic [BITS-1:0]       rd_out_rw1,
    output logic                  init_done
);

    logic                  w_run;
    logic                  w_filling;
    logic [ADDR_WIDTH-1:0] w_fill_addr;
    logic                  w_gnt_any;
    req_id_t               w_gnt_id;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [BITS-1:0]       w_wdata;
    logic [BITS-1:0]       w_wmask;
    logic                  w_in_range;
    logic                  w_rsp_live;
    logic [BITS-1:0]       w_rsp_data;

    logic                  r_pend_rd;
    logic                  r_pend_oor;
    req_id_t               r_pend_id;

`ifdef SRAM_CTRL_INIT_EN
    localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(WORD_DEPTH - 1);

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fill;
    logic                  r_init_done;

    // Zero-fill walker: one word per cycle, then hand over to arbitration.
    always_ff @(posedge clk0) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_fill      <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_fill <= r_fill + 1'b1;
                    if (r_fill == c_last_addr) begin
                        r_state     <= ST_RUN;
                        r_fill      <= '0;
                        r_init_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_run       = (r_state == ST_RUN);
    assign w_filling   = !rst && (r_state == ST_INIT);
    assign w_fill_addr = r_fill;
    assign init_done   = r_init_done;
`else
    assign w_run       = 1'b1;
    assign w_filling   = 1'b0;
    assign w_fill_addr = '0;
    assign init_done   = 1'b1;
`endif

    liteeth_rr_arb2 u_arb (
        .clk     (clk0),
        .rst     (rst),
        .en      (w_run && !rst),
        .valid0  (req0_valid),
        .valid1  (req1_valid),
        .grant0  (req0_ready),
        .grant1  (req1_ready),
        .gnt_any (w_gnt_any),
        .gnt_id  (w_gnt_id)
    );

    // Command of the winning requester.
    always_comb begin
        w_we    = w_gnt_id ? req1_we    : req0_we;
        w_addr  = w_gnt_id ? req1_addr  : req0_addr;
        w_wdata = w_gnt_id ? req1_wdata : req0_wdata;
        w_wmask = w_gnt_id ? req1_wmask : req0_wmask;
    end

    assign w_in_range = (32'(w_addr) < 32'(WORD_DEPTH));

    // Macro drive: zero-fill, an in-range grant, or fully idle.
    always_comb begin
        ce_rw1     = 1'b0;
        we_in_rw1  = 1'b0;
        addr_rw1   = '0;
        wd_in_rw1  = '0;
        w_mask_rw1 = '0;
        if (w_filling) begin
            ce_rw1     = 1'b1;
            we_in_rw1  = 1'b1;
            addr_rw1   = w_fill_addr;
            w_mask_rw1 = '1;
        end else if (w_gnt_any && w_in_range) begin
            ce_rw1     = 1'b1;
            we_in_rw1  = w_we;
            addr_rw1   = w_addr;
            wd_in_rw1  = w_wdata;
            w_mask_rw1 = w_wmask;
        end
    end

    // Accepted reads (in range or not) owe exactly one response next cycle.
    always_ff @(posedge clk0) begin
        if (rst) begin
            r_pend_rd  <= 1'b0;
            r_pend_id  <= 1'b0;
            r_pend_oor <= 1'b0;
        end else begin
            r_pend_rd  <= w_gnt_any && !w_we;
            r_pend_id  <= w_gnt_id;
            r_pend_oor <= !w_in_range;
        end
    end

    // A response still pending when reset arrives is dropped.
    assign w_rsp_live = r_pend_rd && !rst;
    assign w_rsp_data = r_pend_oor ? '0 : rd_out_rw1;

    assign rsp0_valid = w_rsp_live && (r_pend_id == 1'b0);
    assign rsp1_valid = w_rsp_live && (r_pend_id == 1'b1);
    assign rsp0_rdata = rsp0_valid ? w_rsp_data : '0;
    assign rsp1_rdata = rsp1_valid ? w_rsp_data : '0;
    assign rsp0_err   = rsp0_valid && r_pend_oor;
    assign rsp1_err   = rsp1_valid && r_pend_oor;

endmodule
`default_nettype wire

// File: tb/tb_liteeth_sram_rw_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_liteeth_sram_rw_arbiter
// Purpose  : Self-checking bench for liteeth_sram_rw_arbiter with a
//            behavioural 1RW macro model, a reference memory and a response
//            scoreboard. Zero-fill sequences run when SRAM_CTRL_INIT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_liteeth_sram_rw_arbiter;
    import liteeth_sram_pkg::*;

    localparam int BITS       = 32;
    localparam int WORD_DEPTH = 384;
    localparam int ADDR_WIDTH = 9;
    localparam logic [31:0] FF = 32'hFFFF_FFFF;

    logic clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    logic                  rst;
    logic                  req0_valid, req0_ready, req0_we;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [BITS-1:0]       req0_wdata, req0_wmask;
    logic                  req1_valid, req1_ready, req1_we;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [BITS-1:0]       req1_wdata, req1_wmask;
    logic                  rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [BITS-1:0]       rsp0_rdata, rsp1_rdata;
    logic                  ce_rw1, we_in_rw1;
    logic [ADDR_WIDTH-1:0] addr_rw1;
    logic [BITS-1:0]       wd_in_rw1, w_mask_rw1;
    logic [BITS-1:0]       rd_out_rw1 = '0;
    logic                  init_done;

    liteeth_sram_rw_arbiter #(
        .BITS       (BITS),
        .WORD_DEPTH (WORD_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk0       (clk0),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_wmask (req0_wmask),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_wmask (req1_wmask),
        .rsp0_valid (rsp0_valid),
        .rsp0_rdata (rsp0_rdata),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_rdata (rsp1_rdata),
        .rsp1_err   (rsp1_err),
        .ce_rw1     (ce_rw1),
        .we_in_rw1  (we_in_rw1),
        .addr_rw1   (addr_rw1),
        .wd_in_rw1  (wd_in_rw1),
        .w_mask_rw1 (w_mask_rw1),
        .rd_out_rw1 (rd_out_rw1),
        .init_done  (init_done)
    );

    // ---------------- macro model (registered read, bit-masked write) -------
    logic [31:0] mem [0:WORD_DEPTH-1];
    logic        do_preload = 1'b0;

    function automatic logic [31:0] pat(input int i);
        return 32'hA5C3_0000 ^ (32'(i) * 32'h0001_0011);
    endfunction

    always @(posedge clk0) begin
        if (do_preload) begin
            for (int i = 0; i < WORD_DEPTH; i++) mem[i] <= pat(i);
        end else if (ce_rw1 && (32'(addr_rw1) < WORD_DEPTH)) begin
            if (we_in_rw1)
                mem[addr_rw1] <= (mem[addr_rw1] & ~w_mask_rw1) | (wd_in_rw1 & w_mask_rw1);
            else
                rd_out_rw1 <= mem[addr_rw1];
        end
    end

    // ---------------- reference model and scoreboard -------------------------
    typedef struct {
        logic        v0;
        logic        we0;
        logic [8:0]  a0;
        logic [31:0] d0;
        logic [31:0] m0;
        logic        v1;
        logic        we1;
        logic [8:0]  a1;
        logic [31:0] d1;
        logic [31:0] m1;
        logic [1:0]  gnt;   // expected {req1_ready, req0_ready}
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    logic [31:0] ref_mem [0:WORD_DEPTH-1];
    rsp_t        sb [$];
    vec_t        tbl [$];
    int          checks = 0;
    int          errors = 0;

    function automatic vec_t mk(input logic v0, input logic we0, input logic [8:0] a0,
                                input logic [31:0] d0, input logic [31:0] m0,
                                input logic v1, input logic we1, input logic [8:0] a1,
                                input logic [31:0] d1, input logic [31:0] m1,
                                input logic [1:0] gnt);
        vec_t v;
        v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0; v.m0 = m0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1; v.m1 = m1;
        v.gnt = gnt;
        return v;
    endfunction

    function automatic vec_t idle_v();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0;
        req0_wdata = v.d0; req0_wmask = v.m0;
        req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1;
        req1_wdata = v.d1; req1_wmask = v.m1;
    endtask

    task automatic check_rsp();
        rsp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_valid", 128'({rsp1_valid, rsp0_valid}), 128'(e.id ? 2'b10 : 2'b01));
            check("rsp_data", 128'(e.id ? {rsp1_rdata, rsp1_err} : {rsp0_rdata, rsp0_err}),
                  128'({e.data, e.err}));
        end else begin
            check("rsp_idle", 128'({rsp1_valid, rsp0_valid}), 128'(2'b00));
        end
    endtask

    // One cycle: drive, check responses/ready/macro, update model.
    task automatic step(input vec_t v);
        rsp_t        e;
        logic [74:0] m_exp;
        logic        sel, we, inr;
        logic [8:0]  a;
        logic [31:0] d, m;
        @(negedge clk0);
        drive(v);
        #1;
        check_rsp();
        check("ready", 128'({req1_ready, req0_ready}), 128'(v.gnt));
        sel = v.gnt[1];
        we  = sel ? v.we1 : v.we0;
        a   = sel ? v.a1  : v.a0;
        d   = sel ? v.d1  : v.d0;
        m   = sel ? v.m1  : v.m0;
        inr = (a < 9'd384);
        m_exp = '0;
        if (v.gnt != 2'b00 && inr) m_exp = {1'b1, we, a, d, m};
        check("macro", 128'({ce_rw1, we_in_rw1, addr_rw1, wd_in_rw1, w_mask_rw1}), 128'(m_exp));
        if (v.gnt != 2'b00) begin
            if (we) begin
                if (inr) ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
            end else begin
                e.id   = sel;
                e.data = inr ? ref_mem[a] : 32'h0;
                e.err  = !inr;
                sb.push_back(e);
            end
        end
    endtask

`ifdef SRAM_CTRL_INIT_EN
    // Checks a fill walk of n cycles starting at the current cycle.
    task automatic fill_walk(input int n, input logic exp_ready);
        for (int i = 0; i < n; i++) begin
            #1;
            check("fill", 128'({ce_rw1, we_in_rw1, addr_rw1, wd_in_rw1, w_mask_rw1, init_done, req0_ready}),
                  128'({1'b1, 1'b1, 9'(i), 32'h0, FF, 1'b0, exp_ready}));
            if (i == n - 1 && n < WORD_DEPTH) rst = 1'b1;
            @(negedge clk0);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(idle_v());
        do_preload = 1'b1;
        for (int i = 0; i < WORD_DEPTH; i++) ref_mem[i] = pat(i);
        repeat (3) @(negedge clk0);
        do_preload = 1'b0;
        #1;
        check("reset_ready_rsp", 128'({req1_ready, req0_ready, rsp0_valid, rsp1_valid,
                                       rsp0_rdata, rsp1_rdata, rsp0_err, rsp1_err}), 128'(0));
        check("reset_macro", 128'({ce_rw1, we_in_rw1, addr_rw1, wd_in_rw1, w_mask_rw1}), 128'(0));
`ifdef SRAM_CTRL_INIT_EN
        check("reset_init_done", 128'(init_done), 128'(0));
        // Fill up to address 100, reset there, then a complete fill.
        @(negedge clk0); rst = 1'b0;
        fill_walk(101, 1'b0);
        @(negedge clk0); rst = 1'b0;
        drive(mk(1, 0, 9'd0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
        fill_walk(WORD_DEPTH, 1'b0);
        #1;
        for (int i = 0; i < WORD_DEPTH; i++) ref_mem[i] = 32'h0;
        check("init_done_385", 128'(init_done), 128'(1));
        check("first_grant", 128'({req1_ready, req0_ready}), 128'(2'b01));
        check("first_grant_macro", 128'({ce_rw1, we_in_rw1, addr_rw1, wd_in_rw1, w_mask_rw1}),
              128'({1'b1, 1'b0, 9'd0, 32'h0, 32'h0}));
        begin
            rsp_t e;
            e.id = 1'b0; e.data = 32'h0; e.err = 1'b0;
            sb.push_back(e);
        end
        step(mk(0, 0, 0, 0, 0, 1, 0, 9'd200, 0, 0, 2'b10));
        step(mk(1, 0, 9'd383, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        step(mk(0, 0, 0, 0, 0, 1, 0, 9'd5, 0, 0, 2'b10));
`else
        check("reset_init_done", 128'(init_done), 128'(1));
        @(negedge clk0); rst = 1'b0;
`endif
        // Contention, masked writes, out-of-range and priority vectors.
        tbl.push_back(mk(1, 0, 9'd1, 0, 0, 1, 0, 9'd2, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 9'd3, 0, 0, 1, 0, 9'd2, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 9'd3, 0, 0, 1, 0, 9'd4, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 9'd5, 0, 0, 1, 0, 9'd4, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 9'd5, 0, 0, 1, 0, 9'd6, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 9'd7, 0, 0, 1, 0, 9'd6, 0, 0, 2'b10));
        tbl.push_back(idle_v());
        tbl.push_back(mk(1, 1, 9'd5, 32'hDEAD_BEEF, FF, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9'd5, 0, 0, 2'b10));
        tbl.push_back(mk(1, 1, 9'd10, FF, FF, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 9'd10, 32'h0, 32'h0000_FF00, 2'b10));
        tbl.push_back(mk(1, 0, 9'd10, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9'd400, 0, 0, 2'b10));
        tbl.push_back(mk(1, 1, 9'd383, 32'h1234_5678, FF, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 9'd383, 0, 0, 2'b10));
        tbl.push_back(mk(1, 1, 9'd450, 32'hCAFE_F00D, FF, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 9'd7, 0, 0, 1, 0, 9'd8, 0, 0, 2'b10));
        tbl.push_back(mk(1, 0, 9'd7, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(mk(1, 0, 9'd9, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        tbl.push_back(idle_v());
        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Read accepted, then reset: its response must not survive the reset.
        step(mk(1, 0, 9'd2, 0, 0, 0, 0, 0, 0, 0, 2'b01));
        @(negedge clk0);
        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 1, 0, 9'd3, 0, 0, 2'b00));
        void'(sb.pop_front());
        @(negedge clk0);
        rst = 1'b0;
        drive(idle_v());
        #1;
        check("rsp_after_reset", 128'({rsp1_valid, rsp0_valid}), 128'(2'b00));
`ifdef SRAM_CTRL_INIT_EN
        repeat (WORD_DEPTH) @(negedge clk0);
        #1;
        check("refill_done", 128'(init_done), 128'(1));
        for (int i = 0; i < WORD_DEPTH; i++) ref_mem[i] = 32'h0;
`endif
        // Priority pointer is back at requester 0 after reset.
        step(mk(1, 0, 9'd4, 0, 0, 1, 0, 9'd6, 0, 0, 2'b01));
        step(idle_v());
        step(idle_v());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
